// File: rtl/package_settings.sv
// Shared widths, phase constants and the tag that rides alongside each
// operation through the shared phase unit.
package package_settings;

  localparam int SIZE_DATA = 16;
  // Phase scaling: full-scale +pi maps to 2^(SIZE_DATA-1), so pi/2 is a quarter turn.
  localparam logic signed [SIZE_DATA-1:0] PHASE_HALF_PI = 16'sh4000;
  localparam int TAG_CH_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_CH_W-1:0] channel;
    logic                zero_div;
    logic                q_sign;
    logic                q_zero;
  } phase_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: search starts at the pointer and wraps,
// pointer moves just past the winner only when a grant is issued.
module rr_arbiter
  import package_settings::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [NUM_CH-1:0] i_req,
  output logic [NUM_CH-1:0] o_grant,
  output logic [CH_W-1:0]   o_grant_idx,
  output logic              o_grant_vld
);

  logic [CH_W-1:0] r_ptr;

  function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_en && !o_grant_vld && i_req[wrap_idx(r_ptr, i)]) begin
        o_grant_vld                    = 1'b1;
        o_grant_idx                    = wrap_idx(r_ptr, i);
        o_grant[wrap_idx(r_ptr, i)]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (o_grant_vld) begin
      r_ptr <= wrap_idx(o_grant_idx, 1);
    end
  end

endmodule

// File: rtl/phase_arbiter.sv
// Shares one fixed-latency phase unit among NUM_CH requesters; a tag pipeline
// tracks each issued operation so results return in order with their owner.
module phase_arbiter
  import package_settings::*;
#(
  parameter  int NUM_CH        = 4,
  parameter  int PHASE_LATENCY = 4,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          hold,
  input  logic [NUM_CH-1:0]             req_valid,
  output logic [NUM_CH-1:0]             req_ready,
  input  logic [NUM_CH*SIZE_DATA-1:0]   req_i,
  input  logic [NUM_CH*SIZE_DATA-1:0]   req_q,
  output logic signed [SIZE_DATA-1:0]   core_i,
  output logic signed [SIZE_DATA-1:0]   core_q,
  output logic                          core_enable,
  input  logic signed [SIZE_DATA-1:0]   core_phase,
  output logic                          res_valid,
  output logic [CH_W-1:0]               res_channel,
  output logic signed [SIZE_DATA-1:0]   res_phase
);

  logic [NUM_CH-1:0]           w_grant;
  logic [CH_W-1:0]             w_grant_idx;
  logic                        w_accept;
  logic                        w_arb_en;
  logic signed [SIZE_DATA-1:0] w_sel_i;
  logic signed [SIZE_DATA-1:0] w_sel_q;
  phase_tag_t                  w_tag_in;
  phase_tag_t                  w_tag_out;
  phase_tag_t                  r_tag_p [PHASE_LATENCY+1];

  // I == 0 bypasses the core result: the angle is fixed by the sign of Q.
  function automatic logic signed [SIZE_DATA-1:0] resolve_phase(
    input phase_tag_t t, input logic signed [SIZE_DATA-1:0] p);
    if (!t.zero_div) return p;
    if (t.q_zero)    return '0;
    if (t.q_sign)    return -PHASE_HALF_PI;
    return PHASE_HALF_PI;
  endfunction

  assign w_arb_en  = !hold && !reset;
  assign req_ready = w_grant;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .clk         (clk),
    .reset       (reset),
    .i_en        (w_arb_en),
    .i_req       (req_valid),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_vld (w_accept)
  );

  always_comb begin
    w_sel_i = '0;
    w_sel_q = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_grant[k]) begin
        w_sel_i = req_i[k*SIZE_DATA +: SIZE_DATA];
        w_sel_q = req_q[k*SIZE_DATA +: SIZE_DATA];
      end
    end
    w_tag_in          = '0;
    w_tag_in.valid    = w_accept;
    w_tag_in.channel  = TAG_CH_W'(w_grant_idx);
    w_tag_in.zero_div = (w_sel_i == '0);
    w_tag_in.q_sign   = w_sel_q[SIZE_DATA-1];
    w_tag_in.q_zero   = (w_sel_q == '0);
  end

  assign w_tag_out = r_tag_p[PHASE_LATENCY];

  if (CH_W < TAG_CH_W) begin : g_ch_pad
    logic w_unused_ch_bits;
    assign w_unused_ch_bits = |w_tag_out.channel[TAG_CH_W-1:CH_W];
  end

  // Stage p0: operands registered to the phase unit, tag enters the pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      core_enable <= 1'b0;
      core_i      <= '0;
      core_q      <= '0;
      for (int j = 0; j <= PHASE_LATENCY; j++) r_tag_p[j] <= '0;
    end else begin
      core_enable <= w_accept;
      if (w_accept) begin
        core_i <= w_sel_i;
        core_q <= w_sel_q;
      end
      r_tag_p[0] <= w_tag_in;
      for (int j = 1; j <= PHASE_LATENCY; j++) r_tag_p[j] <= r_tag_p[j-1];
    end
  end

  // Stage p(L+1): core result meets its tag and is resolved
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid   <= 1'b0;
      res_channel <= '0;
      res_phase   <= '0;
    end else begin
      res_valid <= w_tag_out.valid;
      if (w_tag_out.valid) begin
        res_channel <= CH_W'(w_tag_out.channel);
        res_phase   <= resolve_phase(w_tag_out, core_phase);
      end
    end
  end

endmodule
